mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one 12x12 unsigned compressor-tree multiplier (mult_12x12_lut6) among NREQ requesters.
//  - Round-robin arbitration, valid/ready handshakes and a stallable result pipeline.
//  - Each result is returned with the ID of the requester that issued it.
//  - Sits between the requesting datapath units and the multiplier instance, which it instantiates internally.
// PARAMETERS
//  NREQ  4   number of requesters; 2..8
//  DW    12  operand width; fixed to match the multiplier instance
//  PIPE  2   accept-to-result latency in cycles; 1..3
//  IDW   2   result-ID width; equals clog2(NREQ)
// PORTS
//  clk        in   1         clock, all state updates on rising edge
//  rst_n      in   1         synchronous reset, active low
//  req_valid  in   NREQ      requester i has an operand pair pending
//  req_ready  out  NREQ      requester i is accepted this cycle
//  req_a      in   NREQ*DW   operand A, requester i at [i*DW +: DW]
//  req_b      in   NREQ*DW   operand B, same packing as req_a
//  out_valid  out  1         result available
//  out_ready  in   1         result consumer accepts
//  out_id     out  IDW       index of the requester that issued the result
//  out_prod   out  2*DW      unsigned product a*b
//  busy       out  1         any pipeline stage holds a valid entry
//  acc_cnt    out  16        number of accepted requests, wraps at 0xFFFF
// BEHAVIOUR
//  Reset:
//  - rst_n sampled low at a clock edge clears all stage valids and sets rr pointer to 0.
//  - Outputs after that edge: out_valid=0, busy=0, acc_cnt=0; out_id/out_prod hold 0.
//  - Mid-operation reset discards all in-flight entries; no result is emitted for them.
//  Handshake:
//  - A transfer occurs in a cycle where valid&&ready are both 1.
//  - Requesters hold valid, a and b stable until accepted.
//  - req_ready is combinational from req_valid; req_valid must not depend on req_ready.
//  - out_valid, out_id and out_prod stay stable while out_valid=1 and out_ready=0.
//  Arbitration:
//  - Each cycle, grant the first valid requester scanning ptr, ptr+1, ... modulo NREQ.
//  - req_ready = onehot(grant) & {NREQ{accept_ok}}; at most one bit is ever set.
//  - accept_ok = first stage empty, or first stage advancing this cycle.
//  - On accept: ptr <= grant+1 mod NREQ. With no accept, ptr holds.
//  Pipeline:
//  - PIPE=1: one stage holding the product of the granted operands.
//  - PIPE=2: operand stage, then product stage.
//  - PIPE=3: operand stage, product stage, extra product stage.
//  - Each stage carries valid, id and data.
//  - The last stage drives out_valid/out_id/out_prod.
//  - Stage k advances when stage k+1 is empty or advancing.
//  - The last stage advances when out_ready=1 or out_valid=0.
//  - Bubbles therefore collapse; sustained throughput is 1 result/cycle with out_ready=1.
//  - Latency: accept in cycle k gives out_valid in cycle k+PIPE, absent stalls.
//  Arithmetic:
//  - The multiplier output is 2*DW+1 bits; the MSB is always 0 for unsigned operands.
//  - out_prod takes bits [2*DW-1:0] only; no rounding, no saturation.
//  Boundaries:
//  - Pipeline full and stalled: req_ready=0 for all requesters; ptr and acc_cnt hold.
//  - Result leaving and new accept in the same cycle are both allowed.
//  - acc_cnt increments by exactly 1 per accept and wraps 0xFFFF->0.
//  - busy=0 only when every stage is empty.
// TESTING
//  T1 PIPE=2: req0 a=3 b=5, accepted cycle 0 -> cycle 2 out_valid=1, id=0, prod=15; busy 1 in cycles 1..2.
//  T2 Max operands: a=b=0xFFF -> prod=0xFFE001; a=0,b=0xFFF -> prod=0.
//  T3 All 4 valid from cycle 0, out_ready=1 -> grants 0,1,2,3 in cycles 0..3; out_id 0,1,2,3 in cycles 2..5.
//  T4 Fairness: req0 always valid, req2 valid from cycle 1 -> grants 0,2,0,2...; req2 never waits >1 accept.
//  T5 out_ready=0 for 4 cycles, 4 reqs queued -> stages fill, req_ready=0, out stable; no loss or duplicate.
//  T6 rst_n low for 1 cycle with 2 entries in flight -> next cycle out_valid=0, busy=0, acc_cnt=0; no late result.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one 12x12 unsigned multiplier among NREQ requesters.
// Results leave through a stallable pipeline tagged with the issuing requester's index.

module mult_12x12_lut6 (
    input  logic [11:0] a_i,
    input  logic [11:0] b_i,
    output logic [24:0] p_o
);
    logic [23:0] prod;
    assign prod = 24'(a_i) * 24'(b_i);
    assign p_o  = {1'b0, prod};
endmodule

module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 12,
    parameter int PIPE = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic [2*DW-1:0]      out_prod,
    output logic                 busy,
    output logic [15:0]          acc_cnt
);
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [15:0]     acc_cnt_q, acc_cnt_d;
    logic [PIPE-1:0] v_q, v_d, ld;
    logic [IDW-1:0]  id_q  [PIPE];
    logic [IDW-1:0]  id_d  [PIPE];
    logic [2*DW-1:0] dat_q [PIPE];
    logic [2*DW-1:0] dat_d [PIPE];

    logic [IDW-1:0]  grant;
    logic            gvalid, accept;
    logic [DW-1:0]   ga, gb, mul_a, mul_b;
    logic [2*DW:0]   mul_p;
    logic            unused_mul_msb;
    logic            in_v;
    logic [IDW-1:0]  in_id;
    logic [2*DW-1:0] in_dat;

    always_comb begin
        int unsigned idx;
        idx    = 0;
        grant  = '0;
        gvalid = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gvalid && req_valid[idx]) begin
                gvalid = 1'b1;
                grant  = IDW'(idx);
            end
        end
    end

    // A stage may load whenever any stage from it to the output is empty, or the output drains.
    always_comb begin
        ld = '0;
        for (int unsigned k = 0; k < PIPE; k++) begin
            ld[k] = out_ready;
            for (int unsigned j = k; j < PIPE; j++) begin
                if (!v_q[j]) ld[k] = 1'b1;
            end
        end
    end

    assign accept    = gvalid & ld[0];
    assign req_ready = accept ? (NREQ'(1) << grant) : '0;
    assign ga        = req_a[grant*DW +: DW];
    assign gb        = req_b[grant*DW +: DW];
    assign ptr_d     = !accept ? ptr_q :
                       (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
    assign acc_cnt_d = accept ? acc_cnt_q + 16'd1 : acc_cnt_q;

    // With PIPE=1 the multiplier sits in front of the only stage; otherwise after the operand stage.
    assign mul_a = (PIPE == 1) ? ga : dat_q[0][2*DW-1:DW];
    assign mul_b = (PIPE == 1) ? gb : dat_q[0][DW-1:0];

    mult_12x12_lut6 u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );
    assign unused_mul_msb = mul_p[2*DW];

    always_comb begin
        in_v   = 1'b0;
        in_id  = '0;
        in_dat = '0;
        for (int unsigned k = 0; k < PIPE; k++) begin
            if (k == 0) begin
                in_v   = accept;
                in_id  = grant;
                in_dat = (PIPE == 1) ? mul_p[2*DW-1:0] : {ga, gb};
            end else begin
                in_v   = v_q[k-1];
                in_id  = id_q[k-1];
                in_dat = (k == 1) ? mul_p[2*DW-1:0] : dat_q[k-1];
            end
            v_d[k]   = ld[k] ? in_v : v_q[k];
            id_d[k]  = (ld[k] && in_v) ? in_id : id_q[k];
            dat_d[k] = (ld[k] && in_v) ? in_dat : dat_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            acc_cnt_q <= '0;
            v_q       <= '0;
            for (int unsigned k = 0; k < PIPE; k++) begin
                id_q[k]  <= '0;
                dat_q[k] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            acc_cnt_q <= acc_cnt_d;
            v_q       <= v_d;
            for (int unsigned k = 0; k < PIPE; k++) begin
                id_q[k]  <= id_d[k];
                dat_q[k] <= dat_d[k];
            end
        end
    end

    assign out_valid = v_q[PIPE-1];
    assign out_id    = id_q[PIPE-1];
    assign out_prod  = dat_q[PIPE-1];
    assign busy      = |v_q;
    assign acc_cnt   = acc_cnt_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter (NREQ=4, PIPE=2): operand table, scoreboard, and arbitration/stall/reset sequences.

module tb_mult_share_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*DW-1:0] req_a, req_b;
    logic              out_valid, out_ready;
    logic [1:0]        out_id;
    logic [2*DW-1:0]   out_prod;
    logic              busy;
    logic [15:0]       acc_cnt;

    mult_share_arbiter #(.NREQ(4), .DW(12), .PIPE(2), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_prod(out_prod), .busy(busy), .acc_cnt(acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] a; logic [11:0] b; logic [23:0] prod; } vec_t;
    typedef struct { logic [1:0] id; logic [23:0] prod; } sb_t;

    vec_t vecs[8];
    sb_t  sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ops(input int i, input logic [11:0] a, input logic [11:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        cyc();
        rst_n = 1'b1;
    endtask

    // Scoreboard: record accepts, compare each emitted result in order.
    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("sb_id", 32'(out_id), 32'(e.id));
                    chk("sb_prod", 32'(out_prod), 32'(e.prod));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_t e;
                    e.id   = 2'(i);
                    e.prod = 24'(req_a[i*DW +: DW]) * 24'(req_b[i*DW +: DW]);
                    sbq.push_back(e);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mask, exp_r;
        int         budget;

        vecs[0] = '{a: 12'd3,    b: 12'd5,    prod: 24'd15};
        vecs[1] = '{a: 12'hFFF,  b: 12'hFFF,  prod: 24'hFFE001};
        vecs[2] = '{a: 12'h000,  b: 12'hFFF,  prod: 24'h000000};
        vecs[3] = '{a: 12'h001,  b: 12'h001,  prod: 24'h000001};
        vecs[4] = '{a: 12'h800,  b: 12'h002,  prod: 24'h001000};
        vecs[5] = '{a: 12'hABC,  b: 12'h010,  prod: 24'h00ABC0};
        vecs[6] = '{a: 12'h123,  b: 12'h003,  prod: 24'h000369};
        vecs[7] = '{a: 12'hFFF,  b: 12'h000,  prod: 24'h000000};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; out_ready = 1'b1;
        @(negedge clk);
        cyc();
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acc_cnt", 32'(acc_cnt), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_prod", 32'(out_prod), 0);
        rst_n = 1'b1;
        cyc();

        // Operand table through requester 0, checking exact two-cycle latency.
        for (int v = 0; v < 8; v++) begin
            req_valid = 4'b0001;
            set_ops(0, vecs[v].a, vecs[v].b);
            #2 chk("tbl_ready", 32'(req_ready), 32'h1);
            cyc();
            req_valid = '0;
            #2 chk("tbl_lat1_valid", 32'(out_valid), 0);
            chk("tbl_lat1_busy", 32'(busy), 1);
            cyc();
            #2 chk("tbl_out_valid", 32'(out_valid), 1);
            chk("tbl_out_id", 32'(out_id), 0);
            chk("tbl_out_prod", 32'(out_prod), 32'(vecs[v].prod));
            chk("tbl_busy", 32'(busy), 1);
            cyc();
            #2 chk("tbl_idle", 32'(busy), 0);
        end
        chk("tbl_acc_cnt", 32'(acc_cnt), 8);

        // All four valid from cycle 0: grants 0..3, results in cycles 2..5.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_ops(i, 12'(10 + i), 12'(20 + i));
        mask = 4'hF;
        for (int c = 0; c < 6; c++) begin
            req_valid = mask;
            exp_r = (c < 4) ? 4'(1 << c) : 4'h0;
            #2 chk("rr_ready", 32'(req_ready), 32'(exp_r));
            if (c >= 2) begin
                chk("rr_out_valid", 32'(out_valid), 1);
                chk("rr_out_id", 32'(out_id), 32'(c - 2));
            end
            mask = mask & ~exp_r;
            cyc();
        end
        req_valid = '0;

        // Fairness: req0 always valid, req2 joins in cycle 1 -> alternate 0,2,0,2.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0101;
            set_ops(0, 12'(c + 1), 12'(c + 2));
            set_ops(2, 12'(c + 100), 12'(c + 3));
            exp_r = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            #2 chk("fair_ready", 32'(req_ready), 32'(exp_r));
            cyc();
        end
        req_valid = '0;
        cyc(); cyc(); cyc();

        // Output stalled for 4 cycles with 4 requests queued.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 12'(i + 1), 12'(i + 7));
        mask = 4'hF;
        for (int c = 0; c < 4; c++) begin
            req_valid = mask;
            exp_r = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
            #2 chk("stall_ready", 32'(req_ready), 32'(exp_r));
            if (c >= 2) begin
                chk("stall_out_valid", 32'(out_valid), 1);
                chk("stall_out_id", 32'(out_id), 0);
                chk("stall_out_prod", 32'(out_prod), 32'd7);
                chk("stall_acc_cnt", 32'(acc_cnt), 2);
            end
            mask = mask & ~exp_r;
            cyc();
        end
        out_ready = 1'b1;
        budget = 20;
        while ((mask != 0 || busy) && budget > 0) begin
            req_valid = mask;
            #2 mask = mask & ~req_ready;
            cyc();
            budget--;
        end
        req_valid = '0;
        if (budget == 0) chk("stall_drain_timeout", 32'(budget), 1);
        #2 chk("stall_acc_final", 32'(acc_cnt), 4);
        chk("stall_sb_empty", 32'(sbq.size()), 0);
        cyc();

        // Reset with two entries in flight: nothing may emerge afterwards.
        do_reset();
        out_ready = 1'b0;
        req_valid = 4'b0001; set_ops(0, 12'd9, 12'd9);
        cyc();
        req_valid = 4'b0010; set_ops(1, 12'd4, 12'd4);
        cyc();
        req_valid = '0;
        rst_n = 1'b0;
        #2 chk("midrst_busy_before", 32'(busy), 1);
        cyc();
        rst_n = 1'b1;
        #2 chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_acc_cnt", 32'(acc_cnt), 0);
        chk("midrst_out_id", 32'(out_id), 0);
        chk("midrst_out_prod", 32'(out_prod), 0);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            #2 chk("midrst_no_late", 32'(out_valid), 0);
        end

        // acc_cnt wrap after 65536 back-to-back accepts.
        do_reset();
        req_valid = 4'b0001; set_ops(0, 12'd2, 12'd3);
        for (int c = 0; c < 65535; c++) cyc();
        #2 chk("wrap_ffff", 32'(acc_cnt), 32'hFFFF);
        cyc();
        #2 chk("wrap_zero", 32'(acc_cnt), 0);
        req_valid = '0;
        cyc(); cyc(); cyc();
        #2 chk("wrap_idle", 32'(busy), 0);
        chk("wrap_sb_empty", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
